kpg_prefix_adder_pipe: RTL and testbench
========================================

Name: kpg_prefix_adder_pipe

Overview:
- Parametrised, pipelined successor to the 64-bit kill/propagate/generate (KPG) carry-lookahead adder used in the Wallace multiplier's final carry-propagate stage.
- Generalised in WIDTH and in the pipeline register spacing across the log2 Kogge-Stone prefix tree.
- Adds an add/subtract mode, a signed-overflow flag and a valid/ready handshake with stall.
- Feeds the multiplier's final-sum path and is reusable as a standalone ALU adder.

Parameters:
- WIDTH, 64: operand width in bits; any power of two from 8 to 128.
- REG_EVERY, 2: prefix levels between pipeline register ranks; 1 to log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB (for sub: 1 means no borrow).
- ovf  out  1  signed overflow.

Behaviour:
- Encoding: each bit i gets a 2-bit KPG code from a[i] and b'[i], where b' = sub ? ~b : b.
  - k (00): both 0. p (01): bits differ. g (10): both 1.
- Position 0 of the prefix vector is the carry-in: g if the effective cin (sub ? 1 : cin) is 1, otherwise k. The vector is WIDTH+1 entries.
- Prefix combine (x o y, x more significant): x=k gives k; x=g gives g; x=p gives y.
- Prefix tree: L = log2(WIDTH) levels of Kogge-Stone span doubling.
- Register ranks:
  - Rank 0 captures the KPG vector, a and b' at the accept edge.
  - One further rank after every REG_EVERY prefix levels; a final partial group also gets a rank.
  - The last rank also holds the sum and flags.
- Latency: R = ceil(L/REG_EVERY) + 1 cycles from the accept edge to out_valid with no stall. WIDTH=64, REG_EVERY=2 gives R=4.
- Sum: sum[i] = a[i]^b'[i]^c[i], where c[i] = 1 iff the prefix result at position i is g. A p result at position i cannot occur once position 0 is k or g.
- cout = 1 iff the prefix result at position WIDTH is g.
- ovf = c[WIDTH-1] ^ cout. It is valid in both modes.
- Handshake:
  - Global advance enable en = out_ready | ~out_valid. in_ready = en, combinationally.
  - On en, every rank shifts one step. Rank 0 loads the input beat and its valid bit is in_valid & in_ready.
  - When en=0, all ranks hold. sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
- Bubbles travel as valid=0 ranks. Throughput is 1 beat per cycle while out_ready=1.
- Input transfer occurs iff in_valid & in_ready. Output transfer occurs iff out_valid & out_ready.
- Reset, asynchronous and possible mid-operation:
  - All rank valid bits clear to 0 and all data registers clear to 0.
  - Outputs read out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - In-flight beats are discarded, never emitted.
- Simultaneous output consume and input accept on the same edge is legal and required for full throughput.
- Ordering: results leave in acceptance order; there is no reordering and no duplication.

Test Plan:
- Reset then a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0, out_ready=1 -> after 4 cycles sum=0, cout=1, ovf=0.
- a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 -> sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
- a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; then a=7, b=5, sub=1 -> sum=2, cout=1.
- Back-to-back stream of 20 random beats, out_ready=1 -> one result per cycle in order, each matching the reference model a+b'+cin.
- Stream with out_ready held 0 for 6 cycles mid-stream -> in_ready=0 once the output rank is valid, sum held stable, no beat lost or duplicated after release.
- rst asserted while 3 beats are in flight -> out_valid=0 immediately and no stale result appears after release.
- Repeat the random stream for WIDTH=16, REG_EVERY=1 (R=5) and WIDTH=32, REG_EVERY=5 (R=2) -> latency and results correct.

Source files
------------

// File: rtl/kpg_prefix_adder_pipe.sv
// Pipelined Kogge-Stone KPG prefix adder with add/subtract, signed overflow and a
// valid/ready handshake whose single advance enable stalls every rank together.
module kpg_prefix_adder_pipe #(
   parameter int WIDTH     = 64,
   parameter int REG_EVERY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int LEVELS  = $clog2(WIDTH);
   localparam int NGROUPS = (LEVELS + REG_EVERY - 1) / REG_EVERY;
   localparam int VW      = 2 * (WIDTH + 1);

   localparam logic [1:0] KPG_K = 2'b00;
   localparam logic [1:0] KPG_P = 2'b01;
   localparam logic [1:0] KPG_G = 2'b10;

   function automatic logic [1:0] kpg_combine(input logic [1:0] x, input logic [1:0] y);
      return (x == KPG_P) ? y : x;
   endfunction

   function automatic int group_last_level(input int g);
      int l;
      l = (g + 1) * REG_EVERY;
      if (l > LEVELS) l = LEVELS;
      return l - 1;
   endfunction

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic [VW-1:0]    kpg_in;

   logic [VW-1:0]    rank_kpg [NGROUPS];
   logic [WIDTH-1:0] rank_a   [NGROUPS];
   logic [WIDTH-1:0] rank_bp  [NGROUPS];
   logic [NGROUPS-1:0] rank_valid;

   logic [VW-1:0]    grp_out [NGROUPS];
   logic [VW-1:0]    pfx_cur;
   logic [VW-1:0]    pfx_nxt;

   logic [VW-1:0]    fin;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             out_valid_q;

   assign en        = out_ready | ~out_valid_q;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   // Entry 0 of the vector is the carry-in; entry i+1 encodes operand bit i.
   always_comb begin
      b_eff = sub ? ~b : b;
      kpg_in = '0;
      kpg_in[1:0] = (sub | cin) ? KPG_G : KPG_K;
      for (int i = 0; i < WIDTH; i++)
         kpg_in[2*(i+1) +: 2] = {a[i] & b_eff[i], a[i] ^ b_eff[i]};
   end

   // Walk the span-doubling levels, reloading from the register rank that opens each group.
   always_comb begin
      for (int g = 0; g < NGROUPS; g++) grp_out[g] = '0;
      pfx_cur = '0;
      pfx_nxt = '0;
      for (int j = 0; j < LEVELS; j++) begin
         if (j % REG_EVERY == 0) pfx_cur = rank_kpg[j / REG_EVERY];
         pfx_nxt = pfx_cur;
         for (int i = (1 << j); i <= WIDTH; i++)
            pfx_nxt[2*i +: 2] = kpg_combine(pfx_cur[2*i +: 2], pfx_cur[2*(i - (1 << j)) +: 2]);
         pfx_cur = pfx_nxt;
         if (j == group_last_level(j / REG_EVERY)) grp_out[j / REG_EVERY] = pfx_nxt;
      end
   end

   // log2(WIDTH) levels leave entry WIDTH spanning bits 1..WIDTH only, so fold in entry 0 for cout.
   always_comb begin
      fin   = grp_out[NGROUPS-1];
      carry = '0;
      for (int i = 0; i < WIDTH; i++) carry[i] = (fin[2*i +: 2] == KPG_G);
      sum_d  = rank_a[NGROUPS-1] ^ rank_bp[NGROUPS-1] ^ carry;
      cout_d = (kpg_combine(fin[2*WIDTH +: 2], fin[1:0]) == KPG_G);
      ovf_d  = carry[WIDTH-1] ^ cout_d;
   end

   // Every rank advances together on en; a held output also freezes the bubbles behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < NGROUPS; g++) begin
            rank_kpg[g] <= '0;
            rank_a[g]   <= '0;
            rank_bp[g]  <= '0;
         end
         rank_valid  <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (en) begin
         rank_kpg[0]   <= kpg_in;
         rank_a[0]     <= a;
         rank_bp[0]    <= b_eff;
         rank_valid[0] <= in_valid & in_ready;
         for (int g = 1; g < NGROUPS; g++) begin
            rank_kpg[g]   <= grp_out[g-1];
            rank_a[g]     <= rank_a[g-1];
            rank_bp[g]    <= rank_bp[g-1];
            rank_valid[g] <= rank_valid[g-1];
         end
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= rank_valid[NGROUPS-1];
      end
   end

endmodule

// File: tb/tb_kpg_prefix_adder_pipe.sv
// Randomised bench for kpg_prefix_adder_pipe: three configurations checked against an
// arithmetic reference model, plus directed vectors, stall and mid-flight reset.
module tb_kpg_prefix_adder_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // WIDTH=64, REG_EVERY=2
   logic        iv64, ir64, cin64, sub64, ov64, or64, co64, of64;
   logic [63:0] a64, b64, sum64;
   // WIDTH=16, REG_EVERY=1
   logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16;
   logic [15:0] a16, b16, sum16;
   // WIDTH=32, REG_EVERY=5
   logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
   logic [31:0] a32, b32, sum32;

   kpg_prefix_adder_pipe #(.WIDTH(64), .REG_EVERY(2)) dut64 (
      .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
      .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(sum64),
      .cout(co64), .ovf(of64));

   kpg_prefix_adder_pipe #(.WIDTH(16), .REG_EVERY(1)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
      .cout(co16), .ovf(of16));

   kpg_prefix_adder_pipe #(.WIDTH(32), .REG_EVERY(5)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
      .cout(co32), .ovf(of32));

   localparam int WIDTH_OF [3] = '{64, 16, 32};
   localparam int LAT_OF   [3] = '{4, 5, 2};

   localparam logic [63:0] DIR_A   [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'd7};
   localparam logic [63:0] DIR_B   [4] = '{64'd0, 64'd1, 64'd7, 64'd5};
   localparam logic        DIR_CIN [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic        DIR_SUB [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   localparam logic [63:0] DIR_SUM [4] = '{64'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2};
   localparam logic        DIR_CO  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   localparam logic        DIR_OVF [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

   logic         obs_ir, obs_ov, obs_co, obs_of;
   logic [127:0] obs_sum;

   // Result of a +/- b as a (w+1)-bit integer sum, with signed overflow from the operand signs.
   function automatic logic [129:0] ref_add(input int w, input logic [127:0] av, input logic [127:0] bv,
                                            input logic cv, input logic sv);
      logic [127:0] mask, am, bp, s;
      logic [128:0] total;
      logic         co, ov;
      mask  = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
      am    = av & mask;
      bp    = (sv ? ~bv : bv) & mask;
      total = {1'b0, am} + {1'b0, bp} + {128'd0, (sv ? 1'b1 : cv)};
      s     = total[127:0] & mask;
      co    = total[w];
      ov    = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
      return {ov, co, s};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Drives one instance at the falling edge and samples its outputs shortly after.
   task automatic drive_cycle(input int sel, input logic iv, input logic [127:0] av, input logic [127:0] bv,
                              input logic cv, input logic sv, input logic orv);
      @(negedge clk);
      case (sel)
         0: begin iv64 = iv; a64 = av[63:0]; b64 = bv[63:0]; cin64 = cv; sub64 = sv; or64 = orv; end
         1: begin iv16 = iv; a16 = av[15:0]; b16 = bv[15:0]; cin16 = cv; sub16 = sv; or16 = orv; end
         default: begin iv32 = iv; a32 = av[31:0]; b32 = bv[31:0]; cin32 = cv; sub32 = sv; or32 = orv; end
      endcase
      #1;
      case (sel)
         0: begin obs_ir = ir64; obs_ov = ov64; obs_sum = {64'd0, sum64}; obs_co = co64; obs_of = of64; end
         1: begin obs_ir = ir16; obs_ov = ov16; obs_sum = {112'd0, sum16}; obs_co = co16; obs_of = of16; end
         default: begin obs_ir = ir32; obs_ov = ov32; obs_sum = {96'd0, sum32}; obs_co = co32; obs_of = of32; end
      endcase
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (ov64 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", ov64); end
      checks++; if (sum64 !== 64'd0) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 0", sum64); end
      checks++; if ({co64, of64} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got cout=%b ovf=%b expected 0 0", co64, of64); end
      checks++; if (ir64 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", ir64); end
      checks++; if ({ov16, ov32} !== 2'b00) begin errors++; $display("[TB] FAIL reset_out_valid_other: got %b%b expected 00", ov16, ov32); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int lat;
      for (int k = 0; k < 4; k++) begin
         drive_cycle(0, 1'b1, {64'd0, DIR_A[k]}, {64'd0, DIR_B[k]}, DIR_CIN[k], DIR_SUB[k], 1'b1);
         checks++; if (obs_ir !== 1'b1) begin errors++; $display("[TB] FAIL dir_accept[%0d]: in_ready got %b expected 1", k, obs_ir); end
         lat = -1;
         for (int n = 1; n <= 12; n++) begin
            drive_cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (obs_ov === 1'b1) begin lat = n; break; end
         end
         checks++;
         if (lat != 4) begin
            errors++; $display("[TB] FAIL dir_latency[%0d]: got %0d cycles expected 4", k, lat);
         end else begin
            checks++;
            if ({obs_of, obs_co, obs_sum[63:0]} !== {DIR_OVF[k], DIR_CO[k], DIR_SUM[k]})
               begin errors++; $display("[TB] FAIL dir_result[%0d]: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                       k, obs_sum[63:0], obs_co, obs_of, DIR_SUM[k], DIR_CO[k], DIR_OVF[k]); end
         end
      end
   endtask

   task automatic test_back_to_back(input int sel, input int nbeats);
      logic [129:0] exp_q [$];
      logic [129:0] e;
      logic [127:0] na, nb;
      logic         nc, ns, iv;
      int           w, r, sent, got, first_seen, calls;
      w = WIDTH_OF[sel]; r = LAT_OF[sel];
      sent = 0; got = 0; first_seen = -1; calls = 0;
      na = rand128(); nb = rand128(); nc = 1'($urandom()); ns = 1'($urandom());
      for (int cyc = 0; cyc < nbeats + r + 20 && got < nbeats; cyc++) begin
         iv = (sent < nbeats);
         drive_cycle(sel, iv, na, nb, nc, ns, 1'b1);
         calls = cyc + 1;
         if (obs_ov === 1'b1) begin
            if (first_seen < 0) first_seen = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("[TB] FAIL b2b_w%0d_extra: result %h appeared with nothing outstanding", w, obs_sum);
            end else begin
               e = exp_q.pop_front();
               got++;
               if ({obs_of, obs_co, obs_sum} !== e)
                  begin errors++; $display("[TB] FAIL b2b_w%0d_beat%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                          w, got - 1, obs_sum, obs_co, obs_of, e[127:0], e[128], e[129]); end
            end
         end
         if (iv && obs_ir === 1'b1) begin
            exp_q.push_back(ref_add(w, na, nb, nc, ns));
            sent++;
            na = rand128(); nb = rand128(); nc = 1'($urandom()); ns = 1'($urandom());
         end
      end
      checks++; if (got != nbeats) begin errors++; $display("[TB] FAIL b2b_w%0d_count: got %0d results expected %0d", w, got, nbeats); end
      checks++; if (first_seen != r) begin errors++; $display("[TB] FAIL b2b_w%0d_latency: got %0d expected %0d", w, first_seen, r); end
      checks++; if (calls != nbeats + r) begin errors++; $display("[TB] FAIL b2b_w%0d_throughput: took %0d cycles expected %0d", w, calls, nbeats + r); end
   endtask

   task automatic test_stall();
      logic [129:0] exp_q [$];
      logic [129:0] e;
      logic [127:0] na, nb;
      logic         nc, ns, iv, orv;
      int           sent, got, extra;
      sent = 0; got = 0; extra = 0;
      na = rand128(); nb = rand128(); nc = 1'($urandom()); ns = 1'($urandom());
      for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
         iv  = (sent < 12);
         orv = !(cyc >= 8 && cyc < 14);
         drive_cycle(0, iv, na, nb, nc, ns, orv);
         if (!orv) begin
            checks++;
            if ({obs_ov, obs_ir} !== 2'b10)
               begin errors++; $display("[TB] FAIL stall_handshake@%0d: got out_valid=%b in_ready=%b expected 1 0", cyc, obs_ov, obs_ir); end
         end
         if (obs_ov === 1'b1 && exp_q.size() != 0) begin
            e = exp_q[0];
            checks++;
            if ({obs_of, obs_co, obs_sum} !== e)
               begin errors++; $display("[TB] FAIL stall_result@%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                       cyc, obs_sum, obs_co, obs_of, e[127:0], e[128], e[129]); end
            if (orv) begin void'(exp_q.pop_front()); got++; end
         end else if (obs_ov === 1'b1) begin
            extra++;
         end
         if (iv && obs_ir === 1'b1) begin
            exp_q.push_back(ref_add(64, na, nb, nc, ns));
            sent++;
            na = rand128(); nb = rand128(); nc = 1'($urandom()); ns = 1'($urandom());
         end
      end
      for (int n = 0; n < 6; n++) begin
         drive_cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         if (obs_ov === 1'b1) extra++;
      end
      checks++; if (got != 12) begin errors++; $display("[TB] FAIL stall_count: got %0d results expected 12", got); end
      checks++; if (extra != 0) begin errors++; $display("[TB] FAIL stall_duplicates: got %0d surplus results expected 0", extra); end
   endtask

   task automatic test_reset_midflight();
      logic [129:0] e;
      int stale, lat;
      for (int k = 0; k < 3; k++) drive_cycle(0, 1'b1, rand128(), rand128(), 1'($urandom()), 1'($urandom()), 1'b1);
      drive_cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      drive_cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_ov !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid: got %b expected 1", obs_ov); end
      rst = 1'b1;
      #1;
      checks++; if (ov64 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", ov64); end
      checks++; if ({sum64, co64, of64} !== 66'd0) begin errors++; $display("[TB] FAIL midrst_data: got sum=%h cout=%b ovf=%b expected zeros", sum64, co64, of64); end
      checks++; if (ir64 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", ir64); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int n = 0; n < 10; n++) begin
         drive_cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         if (obs_ov === 1'b1) stale++;
      end
      checks++; if (stale != 0) begin errors++; $display("[TB] FAIL midrst_stale: got %0d results after reset expected 0", stale); end
      e = ref_add(64, 128'h1234_5678_9ABC_DEF0, 128'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
      drive_cycle(0, 1'b1, 128'h1234_5678_9ABC_DEF0, 128'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 1'b1);
      lat = -1;
      for (int n = 1; n <= 12; n++) begin
         drive_cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         if (obs_ov === 1'b1) begin lat = n; break; end
      end
      checks++;
      if (lat != 4 || {obs_of, obs_co, obs_sum} !== e)
         begin errors++; $display("[TB] FAIL midrst_recover: got lat=%0d sum=%h cout=%b expected lat=4 sum=%h cout=%b",
                                 lat, obs_sum, obs_co, e[127:0], e[128]); end
   endtask

   initial begin
      rst = 1'b1;
      iv64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0; or64 = 1'b1;
      iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
      iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;
      $display("[TB] starting kpg_prefix_adder_pipe bench");
      test_reset();
      test_directed();
      test_back_to_back(0, 20);
      test_stall();
      test_reset_midflight();
      test_back_to_back(1, 20);
      test_back_to_back(2, 20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
